// File: rtl/j1_io_uart_tx_if.sv
// j1 CPU I/O bus as seen by a memory-mapped responder.
// The CPU drives strobes, address and write data; the responder returns registered read data.
interface j1_io_uart_tx_if #(
   parameter int WIDTH = 16
);
   logic             io_we;
   logic             io_re;
   logic [WIDTH-1:0] io_ptr;
   logic [WIDTH-1:0] io_wdata;
   logic [WIDTH-1:0] io_rdata;

   modport master (
      output io_we, io_re, io_ptr, io_wdata,
      input  io_rdata
   );

   modport slave (
      input  io_we, io_re, io_ptr, io_wdata,
      output io_rdata
   );
endinterface

// File: rtl/j1_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the j1 I/O bus: register window, byte FIFO, shifter.
// Read data is zero outside the window so several responders can be OR-combined.
//
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (line low) for one bit period
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (line high); chains straight into S_START if more bytes are queued
module j1_io_uart_tx #(
   parameter logic [15:0] BASE      = 16'hF000,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] DIV_RESET = 16'd16,
   parameter int          WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   j1_io_uart_tx_if.slave       io,
   output logic                 tx,
   output logic                 irq_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state_q, state_d;
   logic [15:0]      baud_q, baud_d;
   logic [15:0]      period_q, period_d;
   logic [15:0]      div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             tx_q, tx_d;
   logic             irq_q, irq_d;

   logic             pop, push, push_ok;
   logic             fifo_empty, fifo_full, busy, bit_end;
   logic             hit_data, hit_stat, hit_div;
   logic [7:0]       stat8;

   assign hit_data   = (io.io_ptr == WIDTH'(BASE));
   assign hit_stat   = (io.io_ptr == WIDTH'(BASE + 16'd1));
   assign hit_div    = (io.io_ptr == WIDTH'(BASE + 16'd2));

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign busy       = (state_q != S_IDLE) || !fifo_empty;
   assign stat8      = {4'(count_q), ovf_q, fifo_empty, fifo_full, busy};
   assign bit_end    = (baud_q == 16'd0);

   assign push       = io.io_we && hit_data;
   assign push_ok    = push && (!fifo_full || pop);

   assign tx          = tx_q;
   assign irq_empty   = irq_q;
   assign io.io_rdata = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= 16'd0;
         period_q <= DIV_RESET;
         div_q    <= DIV_RESET;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
         tx_q     <= 1'b1;
         irq_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         period_q <= period_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         tx_q     <= tx_d;
         irq_q    <= irq_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= io.io_wdata[7:0];
   end

   // Each pop latches DIV so a divisor write only affects frames not yet started.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      period_d = period_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_d  = mem_q[rd_ptr_q];
               period_d = div_q;
               baud_d   = div_q - 16'd1;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_d  = period_q - 16'd1;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d  = period_q - 16'd1;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  shift_d  = mem_q[rd_ptr_q];
                  period_d = div_q;
                  baud_d   = div_q - 16'd1;
                  state_d  = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      irq_d = (count_d == '0) && (state_d == S_IDLE);
   end

   // Register file; reads use the pre-write register values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      div_d    = div_q;
      rdata_d  = '0;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (push && fifo_full && !pop) ovf_d = 1'b1;
      else if (io.io_we && hit_stat && io.io_wdata[3]) ovf_d = 1'b0;
      if (io.io_we && hit_div)
         div_d = (io.io_wdata[15:0] == 16'd0) ? 16'd1 : io.io_wdata[15:0];
      if (io.io_re) begin
         if (hit_stat)     rdata_d = WIDTH'(stat8);
         else if (hit_div) rdata_d = WIDTH'(div_q);
      end
   end

endmodule

// File: tb/tb_j1_io_uart_tx.sv
// Directed bench for j1_io_uart_tx: register access, framing, FIFO overflow, divisor and decode behaviour.
module tb_j1_io_uart_tx;
   localparam logic [15:0] BASE = 16'hF000;

   logic clk = 1'b0;
   logic rst;
   logic tx;
   logic irq_empty;
   logic [15:0] d;

   int checks   = 0;
   int failures = 0;

   j1_io_uart_tx_if #(.WIDTH(16)) bus ();

   j1_io_uart_tx #(
      .BASE(BASE), .DEPTH(4), .DIV_RESET(16'd16), .WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .io(bus), .tx(tx), .irq_empty(irq_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] v);
      bus.io_we = 1'b1; bus.io_ptr = a; bus.io_wdata = v;
      tick();
      bus.io_we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      bus.io_re = 1'b1; bus.io_ptr = a;
      tick();
      v = bus.io_rdata;
      bus.io_re = 1'b0;
   endtask

   task automatic rw(input logic [15:0] a, input logic [15:0] wv, output logic [15:0] v);
      bus.io_we = 1'b1; bus.io_re = 1'b1; bus.io_ptr = a; bus.io_wdata = wv;
      tick();
      v = bus.io_rdata;
      bus.io_we = 1'b0; bus.io_re = 1'b0;
   endtask

   // Samples one frame clock by clock; clock c of the frame carries bit c/div.
   task automatic check_frame(input string tag, input logic [7:0] b, input int div, input int skip);
      int bad;
      int k;
      logic e;
      bad = 0;
      for (int c = skip; c < 10 * div; c++) begin
         k = c / div;
         e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         if (tx !== e) bad++;
         tick();
      end
      chk(tag, bad, 0);
   endtask

   task automatic check_quiet(input string tag, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (tx !== 1'b1) bad++;
         tick();
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.io_we = 1'b0; bus.io_re = 1'b0; bus.io_ptr = '0; bus.io_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_irq", irq_empty, 1);
      chk("rst_rdata", bus.io_rdata, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_tx", tx, 1);
      chk("post_rst_irq", irq_empty, 1);
      rd(BASE + 16'd2, d); chk("rst_div", d, 16);
      rd(BASE + 16'd1, d); chk("rst_status", d, 16'h004);
      rd(BASE, d);         chk("txdata_reads_zero", d, 0);

      // single byte at DIV=4
      wr(BASE + 16'd2, 16'd4);
      wr(BASE, 16'h005A);
      chk("tx_high_at_push", tx, 1);
      chk("irq_low_after_push", irq_empty, 0);
      tick();
      chk("tx_fall", tx, 0);
      check_frame("frame_5a", 8'h5A, 4, 0);
      chk("irq_after_5a", irq_empty, 1);
      chk("tx_idle_after_5a", tx, 1);

      // overflow at DIV=100
      wr(BASE + 16'd2, 16'd100);
      wr(BASE, 16'h0011);
      wr(BASE, 16'h0022);
      wr(BASE, 16'h0033);
      wr(BASE, 16'h0044);
      wr(BASE, 16'h0055);
      wr(BASE, 16'h0066);
      rd(BASE + 16'd1, d); chk("status_ovf", d, 16'h04B);
      wr(BASE + 16'd1, 16'h0008);
      rd(BASE + 16'd1, d); chk("status_ovf_clr", d, 16'h043);
      check_frame("ovf_f1", 8'h11, 100, 7);
      check_frame("ovf_f2", 8'h22, 100, 0);
      check_frame("ovf_f3", 8'h33, 100, 0);
      check_frame("ovf_f4", 8'h44, 100, 0);
      check_frame("ovf_f5", 8'h55, 100, 0);
      chk("ovf_irq_done", irq_empty, 1);
      check_quiet("ovf_no_6th", 20);
      rd(BASE + 16'd1, d); chk("ovf_status_end", d, 16'h004);

      // push into a full FIFO on the cycle the stop bit ends
      wr(BASE + 16'd2, 16'd4);
      wr(BASE, 16'h00A1);
      wr(BASE, 16'h00B2);
      wr(BASE, 16'h00C3);
      wr(BASE, 16'h00D4);
      wr(BASE, 16'h00E5);
      repeat (36) tick();
      wr(BASE, 16'h00F6);
      chk("b2b_start", tx, 0);
      rd(BASE + 16'd1, d); chk("full_pop_status", d, 16'h043);
      check_frame("fp_b2", 8'hB2, 4, 1);
      check_frame("fp_c3", 8'hC3, 4, 0);
      check_frame("fp_d4", 8'hD4, 4, 0);
      check_frame("fp_e5", 8'hE5, 4, 0);
      check_frame("fp_f6", 8'hF6, 4, 0);
      chk("fp_irq_done", irq_empty, 1);

      // divisor write during a frame
      wr(BASE, 16'h003C);
      wr(BASE, 16'h00A5);
      repeat (5) tick();
      wr(BASE + 16'd2, 16'd0);
      check_frame("div_frame_a", 8'h3C, 4, 6);
      check_frame("div_frame_b", 8'hA5, 1, 0);
      chk("div_irq_done", irq_empty, 1);
      rd(BASE + 16'd2, d); chk("div_zero_as_one", d, 1);

      // decode
      rd(BASE + 16'd3, d); chk("rd_base_p3", d, 0);
      rd(BASE + 16'd2, d); chk("rd_div_again", d, 1);
      rd(BASE - 16'd1, d); chk("rd_base_m1", d, 0);
      wr(BASE - 16'd1, 16'h0008);
      wr(BASE + 16'd3, 16'h0055);
      chk("decode_tx_idle", tx, 1);
      rd(BASE + 16'd1, d); chk("decode_status", d, 16'h004);
      rd(BASE + 16'd2, d); chk("decode_div", d, 1);
      rw(BASE + 16'd2, 16'd7, d); chk("rw_old_div", d, 1);
      rd(BASE + 16'd2, d); chk("rw_new_div", d, 7);

      // reset mid-frame
      wr(BASE, 16'h0000);
      tick();
      chk("mr_tx_fall", tx, 0);
      wr(BASE, 16'h0012);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("mr_tx", tx, 1);
      chk("mr_irq", irq_empty, 1);
      tick();
      rst = 1'b0;
      tick();
      rd(BASE + 16'd1, d); chk("mr_status", d, 16'h004);
      rd(BASE + 16'd2, d); chk("mr_div", d, 16);
      check_quiet("mr_quiet", 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/j1_io_uart_tx.md
# j1_io_uart_tx

Memory-mapped UART transmitter that responds on the j1 I/O bus: the CPU initiates `io_we`/`io_re` cycles at `io_ptr`, and this block decodes its register window, buffers bytes in a small FIFO, and serialises them 8N1, LSB first, on `tx`. It sits beside the data RAM on the same I/O strobes. Read data is registered, giving the same one-cycle read latency as RAM. Outside its window it drives zero so its read data can be OR-combined with other responders.

## Interface
Parameters:
- `BASE`, 16'hF000: word address of register 0. Registers occupy BASE+0..BASE+2.
- `DEPTH`, 4: FIFO depth in bytes. Must be a power of two, 2..8.
- `DIV_RESET`, 16'd16: reset value of the baud divisor, in clocks per bit.

Ports (`WIDTH` from `common.h`):
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: reset, **asynchronous, active-high**.
- `io_we` in 1: CPU write strobe.
- `io_re` in 1: CPU read strobe.
- `io_ptr` in `WIDTH`: CPU I/O address.
- `io_wdata` in `WIDTH`: CPU write data (the CPU's N).
- `io_rdata` out `WIDTH`: registered read data to the CPU.
- `tx` out 1: serial line. Idles high.
- `irq_empty` out 1: high while the FIFO is empty and the shifter is idle.

## Operation
- Register map:
  - BASE+0 TXDATA, write-only; reads return 0. A write pushes `io_wdata[7:0]`.
    - If the FIFO is full and no pop happens the same cycle, the byte is dropped and sticky OVF is set.
  - BASE+1 STATUS, read:
    - bit0 BUSY = shifter active or FIFO non-empty.
    - bit1 FULL. bit2 EMPTY (FIFO). bit3 OVF.
    - bits[7:4] COUNT (0..DEPTH). All other bits 0.
  - BASE+1 STATUS, write: bit3=1 clears OVF. Other bits are ignored.
  - BASE+2 DIV, read/write, 16 bits. A written value of 0 is stored as 1.
- Address mismatch: no state change. `io_rdata` <= 0.
- Read-only access (io_re without io_we): `io_rdata` <= register value on a hit, else 0.
- `io_we` and `io_re` together on the same address:
  - the read returns the pre-write value;
  - the write takes effect.
- Shifter FSM: IDLE -> START -> DATA -> STOP -> (START | IDLE).
  - IDLE: `tx`=1. If the FIFO is non-empty:
    - pop the head into the shift register;
    - latch DIV into the bit period;
    - go to START.
  - START: `tx`=0 for one bit period.
  - DATA: 8 bit periods, LSB first. A 3-bit counter tracks the bit; it wraps 7 -> exit.
  - STOP: `tx`=1 for one bit period. At the end:
    - FIFO non-empty: pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- The baud counter reloads to DIV-1 at each bit start and counts down to 0.
- A DIV write mid-frame does not affect the current frame.
- Push and pop in the same cycle:
  - both are performed;
  - COUNT is unchanged;
  - a push to a full FIFO is accepted in this case (no OVF).
- FIFO pointers are log2(DEPTH) bits and wrap. COUNT is log2(DEPTH)+1 bits.
- `irq_empty` = EMPTY & (state == IDLE), registered.

## Timing
- Reset (asynchronous assert) sets:
  - `tx`=1, `io_rdata`=0, `irq_empty`=1;
  - FIFO empty, OVF=0, DIV=DIV_RESET, state IDLE.
- Reset asserted mid-frame aborts the frame at once: `tx`=1 and the FIFO contents are discarded.
- Read latency: strobe sampled at edge n -> `io_rdata` valid after edge n, held until edge n+1.
- Write to TXDATA at edge n:
  - COUNT reflects it after edge n.
  - If IDLE, the pop happens at edge n+1 and `tx` falls after edge n+1.
- Frame length: exactly 10×DIV clocks from the `tx` fall to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the clock right after the last stop-bit clock.

## Test plan
- Reset: hold `rst`, then release. Check `tx`=1, `irq_empty`=1, `io_rdata`=0. A read of BASE+2 returns 16 on the next cycle. A read of BASE+1 returns 0x004.
- Single byte, DIV=4: write 0x5A to BASE+0.
  - `tx` falls one cycle later.
  - Line then carries 0, 0,1,0,1,1,0,1,0, 1 (start, LSB-first data, stop), 4 clocks each; 40 clocks total.
  - `irq_empty` returns to 1 afterwards.
- Overflow, DIV=100: write 6 bytes on consecutive cycles.
  - First is popped; the next 4 fill the FIFO; the 6th sets OVF.
  - STATUS = 0x04B (COUNT=4, OVF, FULL, BUSY).
  - Write 0x8 to BASE+1: OVF clears.
  - Exactly 5 frames are transmitted, back-to-back with no idle gap.
- Full FIFO with a same-cycle pop: time a write to coincide with the stop-bit end of the current frame while FULL.
  - Byte is accepted, OVF stays 0, COUNT stays 4.
- DIV change mid-frame: DIV=4, start frame A, write DIV=0 during DATA.
  - A completes at 4 clocks/bit.
  - Next frame B runs at 1 clock/bit (0 stored as 1); a read of DIV returns 1.
- Decode: read/write at BASE+3 and BASE-1. No state change, `io_rdata`=0.
  - Simultaneous we+re at BASE+2 returns the old DIV, then the new DIV on the following read.
